// File: rtl/jug_fault_filter_pkg.sv
// ----------------------------------------------------------------------------
// jug_fault_filter_pkg
// Shared definitions for the judgement-result fault filter:
//   - state_t   : filter FSM state encoding (3 bits)
//   - TYPE_LO/HI: bit positions inside fault_type
//   - type_bits : packs the two raw judgement bits into fault_type layout
// ----------------------------------------------------------------------------
package jug_fault_filter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_NORMAL  = 3'd1,
      ST_CONFIRM = 3'd2,
      ST_FAULT   = 3'd3,
      ST_RECOVER = 3'd4
   } state_t;

   localparam int TYPE_LO = 0;
   localparam int TYPE_HI = 1;

   function automatic logic [1:0] type_bits(input logic lo, input logic hi);
      logic [1:0] t;
      t          = 2'b00;
      t[TYPE_LO] = lo;
      t[TYPE_HI] = hi;
      return t;
   endfunction

endpackage

// File: rtl/jug_fault_filter_if.sv
// ----------------------------------------------------------------------------
// jug_fault_filter_if
// Bundles the judgement inputs and fault status outputs of one channel.
//   master : judge/host side (drives enable, strobe, judgement bits, clear)
//   slave  : filter side (drives fault status, count and debug state)
//
// Handshake: sample_vld is a one-cycle strobe qualifying jug_result_lo/hi in
// the same cycle. There is no ready; the filter accepts every strobe.
// fault_clr is a one-cycle pulse with the same no-backpressure semantics.
// ----------------------------------------------------------------------------
interface jug_fault_filter_if #(
   parameter int CNT_W = 16
);
   import jug_fault_filter_pkg::*;

   logic             chn_dgd_en;
   logic             sample_vld;
   logic             jug_result_lo;
   logic             jug_result_hi;
   logic             fault_clr;
   logic             fault_flag;
   logic [1:0]       fault_type;
   logic             fault_pulse;
   logic [CNT_W-1:0] flt_cnt;
   state_t           dbg_state;

   modport master (
      output chn_dgd_en, sample_vld, jug_result_lo, jug_result_hi, fault_clr,
      input  fault_flag, fault_type, fault_pulse, flt_cnt, dbg_state
   );

   modport slave (
      input  chn_dgd_en, sample_vld, jug_result_lo, jug_result_hi, fault_clr,
      output fault_flag, fault_type, fault_pulse, flt_cnt, dbg_state
   );

endinterface

// File: rtl/jug_fault_filter.sv
// ----------------------------------------------------------------------------
// jug_fault_filter
// Debounces per-channel low/high threshold judgement bits and reports a
// confirmed fault with its type. The fault is released after CLR_CNT
// consecutive normal samples, or, with LATCH_EN = 1, only by fault_clr.
// Ports:
//   clk_sys   : system clock
//   rst_sys_n : asynchronous active-low reset
//   bus       : jug_fault_filter_if.slave (inputs, fault status, debug state)
// All outputs are registered.
// ----------------------------------------------------------------------------
module jug_fault_filter
   import jug_fault_filter_pkg::*;
#(
   parameter int               CNT_W    = 16,
   parameter logic [CNT_W-1:0] SET_CNT  = 16'd8,
   parameter logic [CNT_W-1:0] CLR_CNT  = 16'd16,
   parameter logic             LATCH_EN = 1'b0
) (
   input logic               clk_sys,
   input logic               rst_sys_n,
   jug_fault_filter_if.slave bus
);

   state_t           state_q;
   logic             flag_q;
   logic [1:0]       type_q;
   logic [1:0]       pend_q;
   logic             pulse_q;
   logic [CNT_W-1:0] cnt_q;

   logic             raw;
   logic [1:0]       bits;
   logic [CNT_W-1:0] cnt_d;

   assign raw   = bus.jug_result_lo | bus.jug_result_hi;
   assign bits  = type_bits(bus.jug_result_lo, bus.jug_result_hi);
   assign cnt_d = cnt_q + 1'b1;

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         state_q <= ST_IDLE;
         flag_q  <= 1'b0;
         type_q  <= 2'b00;
         pend_q  <= 2'b00;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pulse_q <= 1'b0;
         if (!bus.chn_dgd_en) begin
            // Disable overrides clear and samples in every state.
            state_q <= ST_IDLE;
            flag_q  <= 1'b0;
            type_q  <= 2'b00;
            pend_q  <= 2'b00;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  // The enabling cycle only arms the filter; its sample is dropped.
                  state_q <= ST_NORMAL;
               end
               ST_NORMAL: begin
                  if (bus.sample_vld && raw) begin
                     state_q <= ST_CONFIRM;
                     cnt_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
                     pend_q  <= bits;
                  end
               end
               ST_CONFIRM: begin
                  if (bus.sample_vld) begin
                     if (raw) begin
                        if (cnt_d == SET_CNT) begin
                           state_q <= ST_FAULT;
                           cnt_q   <= '0;
                           flag_q  <= 1'b1;
                           type_q  <= pend_q | bits;
                           pend_q  <= 2'b00;
                           pulse_q <= 1'b1;
                        end else begin
                           cnt_q  <= cnt_d;
                           pend_q <= pend_q | bits;
                        end
                     end else begin
                        state_q <= ST_NORMAL;
                        cnt_q   <= '0;
                        pend_q  <= 2'b00;
                     end
                  end
               end
               ST_FAULT: begin
                  if (LATCH_EN && bus.fault_clr) begin
                     // Clear wins over a coincident sample, which is discarded.
                     state_q <= ST_NORMAL;
                     flag_q  <= 1'b0;
                     type_q  <= 2'b00;
                     cnt_q   <= '0;
                  end else if (bus.sample_vld) begin
                     if (raw) begin
                        type_q <= type_q | bits;
                     end else if (!LATCH_EN) begin
                        state_q <= ST_RECOVER;
                        cnt_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
                     end
                  end
               end
               ST_RECOVER: begin
                  if (bus.sample_vld) begin
                     if (raw) begin
                        state_q <= ST_FAULT;
                        cnt_q   <= '0;
                        type_q  <= type_q | bits;
                     end else if (cnt_d == CLR_CNT) begin
                        state_q <= ST_NORMAL;
                        flag_q  <= 1'b0;
                        type_q  <= 2'b00;
                        cnt_q   <= '0;
                     end else begin
                        cnt_q <= cnt_d;
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  flag_q  <= 1'b0;
                  type_q  <= 2'b00;
                  pend_q  <= 2'b00;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.fault_flag  = flag_q;
   assign bus.fault_type  = type_q;
   assign bus.fault_pulse = pulse_q;
   assign bus.flt_cnt     = cnt_q;
   assign bus.dbg_state   = state_q;

endmodule
